layer_seq_ctrl: RTL and testbench
=================================

# layer_seq_ctrl

Sequencer for one fully-connected layer. It buffers one input activation vector, then broadcasts it as a single contiguous burst to every neuron of the layer in parallel. It then collects each neuron's result as it becomes valid and streams the results out, in neuron order, to the next layer. The block sits between two layers and owns all `myinput` / `myinputValid` timing for the neurons it drives.

## Interface
- `NUM_INPUTS`, 784, activations per vector (the neurons' `numWeight`)
- `NUM_NEURONS`, 30, neurons in the layer
- `DATA_WIDTH`, 16, activation / result width
- `TIMEOUT_CYCLES`, 4096, WAIT watchdog limit (used only with `LAYER_SEQ_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `in_data`  in  DATA_WIDTH  incoming activation
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block accepts activations
- `nrn_data`  out  DATA_WIDTH  broadcast to all neurons' `myinput`
- `nrn_valid`  out  1  broadcast to all neurons' `myinputValid`
- `nrn_out`  in  NUM_NEURONS*DATA_WIDTH  neuron results; neuron i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `nrn_outvalid`  in  NUM_NEURONS  per-neuron `outvalid` pulses
- `out_data`  out  DATA_WIDTH  result to next layer
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  next layer accepts
- `busy`  out  1  state ≠ LOAD, or LOAD with at least one sample accepted
- `layer_done`  out  1  one-cycle pulse after the last result handshake
- `err`  out  1  sticky watchdog flag

## Operation
- States: LOAD (reset state), BCAST, WAIT, DRAIN.
- **LOAD**
  - `in_ready`=1.
  - Each `in_valid & in_ready` writes `in_data` to buffer[wr_idx] and increments wr_idx.
  - On the accept with wr_idx = NUM_INPUTS-1: go to BCAST, deassert `in_ready` on the next cycle, clear wr_idx.
- **BCAST**
  - Issues buffer reads at addresses 0..NUM_INPUTS-1 on consecutive cycles. The buffer is synchronous-read with 1-cycle latency.
  - `nrn_data` / `nrn_valid` are registered from the read data, so `nrn_valid` is high for exactly NUM_INPUTS contiguous cycles with no gaps. The neurons require a contiguous burst.
  - After issuing the last address: go to WAIT.
  - Clears the capture mask on entry.
- **Capture** (active in BCAST and WAIT)
  - For each i with `nrn_outvalid[i]`=1: latch `nrn_out` slice i into res[i] and set mask[i].
  - A repeat pulse overwrites res[i].
  - Pulses are ignored in LOAD and DRAIN.
- **WAIT**: when mask is all ones (including the same cycle as the last pulse), go to DRAIN on the next edge.
- **DRAIN**
  - `out_valid`=1 and `out_data`=res[rd_idx], starting at rd_idx=0.
  - On `out_valid & out_ready`: increment rd_idx.
  - Data is held stable while `out_ready`=0.
  - After the handshake at rd_idx = NUM_NEURONS-1: pulse `layer_done` for 1 cycle and return to LOAD.
- A new vector may begin loading in the cycle after `layer_done`.
- Reset mid-operation:
  - State returns to LOAD; indices, mask and `nrn_valid` are cleared.
  - Buffer and res contents are don't-care.
  - A neuron `outvalid` arriving after reset is ignored.

## Timing
- Reset values: `in_ready`=0, `nrn_valid`=0, `nrn_data`=0, `out_valid`=0, `out_data`=0, `busy`=0, `layer_done`=0, `err`=0.
- `in_ready` rises in the first cycle after `rst` falls.
- Last LOAD accept at edge T:
  - BCAST occupies T+1..T+NUM_INPUTS.
  - `nrn_valid` is high in cycles T+2..T+NUM_INPUTS+1.
  - The first WAIT cycle coincides with the last `nrn_valid` cycle.
- All outvalid pulses seen by edge E: `out_valid` is high from E+1.
- Throughput: 1 activation per cycle in; 1 result per cycle out when `out_ready` is held high.
- Index counters are $clog2(N)+1 bits wide and never wrap; they are cleared on state exit.

## Configuration
- `LAYER_SEQ_TIMEOUT_EN` defined:
  - A WAIT cycle counter resets on WAIT entry.
  - When it reaches TIMEOUT_CYCLES with the mask incomplete: set `err` (sticky until `rst`), go to DRAIN, and emit 0 for every neuron whose mask bit is clear.
- Not defined:
  - WAIT blocks indefinitely.
  - `err` is tied 0.
  - No counter logic is synthesized.

## Test plan
Params: NUM_INPUTS=4, NUM_NEURONS=3, TIMEOUT_CYCLES=8.

1. **Reset**: hold `rst` 3 cycles → all outputs 0 during reset; `in_ready`=1 one cycle after release.
2. **Gapped load**: load 0x0010, 0x0020, 0x0030, 0x0040 with `in_valid` gaps → `in_ready` low after the 4th accept; `nrn_valid` high exactly 4 consecutive cycles carrying 0x0010..0x0040 in order.
3. **Skewed completion and backpressure**: neuron 0 outvalid 2 cycles into WAIT with 0x0100; neurons 1 and 2 at 5 cycles with 0x0200 and 0x0300; `out_ready` low 3 cycles on the second word → outputs 0x0100, 0x0200, 0x0300, with 0x0200 held stable throughout the stall; `layer_done` pulses once.
4. **Watchdog** (`LAYER_SEQ_TIMEOUT_EN`): neuron 2 never pulses → `err`=1 eight cycles after WAIT entry; drain emits res0, res1, 0x0000.
5. **Reset mid-BCAST**: assert `rst` on the 2nd `nrn_valid` cycle → `nrn_valid`=0 next cycle, state is LOAD; a fresh 4-sample vector then broadcasts correctly.
6. **Back-to-back vectors**: two vectors loaded consecutively → the second load starts the cycle after `layer_done`, and both result sets are correct.

Source files
------------

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl
// ----------------------------------------------------------------------------
// Sequencer for one fully-connected layer.
//   LOAD  : buffer one activation vector (NUM_INPUTS samples) into block RAM.
//   BCAST : replay the vector to every neuron as one gap-free burst.
//   WAIT  : wait until every neuron has reported a result.
//   DRAIN : stream the results out in neuron order with valid/ready.
// Neuron results are captured on their outvalid pulses while in BCAST or WAIT.
//
// Optional build macro:
//   LAYER_SEQ_TIMEOUT_EN - WAIT watchdog. After TIMEOUT_CYCLES cycles in WAIT
//   with results still missing, set the sticky err flag and drain anyway.
//   Neurons that never reported are drained as zero. When the macro is not
//   defined, WAIT blocks indefinitely and err is tied low.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_data/in_valid/in_ready      activation input stream
//   nrn_data/nrn_valid             broadcast to all neurons (myinput/myinputValid)
//   nrn_out/nrn_outvalid           neuron results; neuron i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_data/out_valid/out_ready   result stream to the next layer
//   busy            high whenever a vector is in flight
//   layer_done      one-cycle pulse after the last result handshake
//   err             sticky watchdog flag
// ----------------------------------------------------------------------------
module layer_seq_ctrl #(
  parameter int NUM_INPUTS     = 784,
  parameter int NUM_NEURONS    = 30,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_WIDTH-1:0]             nrn_data,
  output logic                              nrn_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] nrn_out,
  input  logic [NUM_NEURONS-1:0]            nrn_outvalid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              layer_done,
  output logic                              err
);

  localparam int IW  = $clog2(NUM_INPUTS) + 1;
  localparam int NW  = $clog2(NUM_NEURONS) + 1;
  localparam int IAW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
  localparam int NAW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_BCAST = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [IW-1:0]          wr_idx_reg;
  logic [IW-1:0]          bc_idx_reg;
  logic [NW-1:0]          rd_idx_reg;
  logic [NUM_NEURONS-1:0] mask_reg;
  logic                   in_ready_reg;
  logic                   nrn_valid_reg;
  logic [DATA_WIDTH-1:0]  nrn_data_reg;
  logic                   layer_done_reg;

  logic [DATA_WIDTH-1:0]  buf_mem [NUM_INPUTS];
  logic [DATA_WIDTH-1:0]  res_reg [NUM_NEURONS];

  logic                   in_fire;
  logic                   out_fire;
  logic                   capture_en;
  logic                   mask_all;
  logic                   last_in;
  logic                   last_bc;
  logic                   last_rd;
  logic                   timeout_hit;
  logic [DATA_WIDTH-1:0]  res_sel;

  assign in_fire    = in_valid && in_ready_reg && (state_reg == ST_LOAD);
  assign out_fire   = (state_reg == ST_DRAIN) && out_ready;
  assign capture_en = (state_reg == ST_BCAST) || (state_reg == ST_WAIT);
  // Include this cycle's pulses so the last result moves us on at the very next edge.
  assign mask_all   = &(mask_reg | nrn_outvalid);
  assign last_in    = (wr_idx_reg == IW'(NUM_INPUTS - 1));
  assign last_bc    = (bc_idx_reg == IW'(NUM_INPUTS - 1));
  assign last_rd    = (rd_idx_reg == NW'(NUM_NEURONS - 1));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD:  if (in_fire && last_in)          state_next = ST_BCAST;
      ST_BCAST: if (last_bc)                     state_next = ST_WAIT;
      ST_WAIT:  if (mask_all || timeout_hit)     state_next = ST_DRAIN;
      ST_DRAIN: if (out_fire && last_rd)         state_next = ST_LOAD;
      default:                                   state_next = ST_LOAD;
    endcase
  end

  // --------------------------------------------------------------------------
  // Indices, handshake flags, capture mask
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_reg     <= '0;
      bc_idx_reg     <= '0;
      rd_idx_reg     <= '0;
      mask_reg       <= '0;
      in_ready_reg   <= 1'b0;
      layer_done_reg <= 1'b0;
    end else begin
      if (in_fire) begin
        wr_idx_reg <= last_in ? '0 : wr_idx_reg + IW'(1);
      end
      if (state_reg == ST_BCAST) begin
        bc_idx_reg <= last_bc ? '0 : bc_idx_reg + IW'(1);
      end
      if (out_fire) begin
        rd_idx_reg <= last_rd ? '0 : rd_idx_reg + NW'(1);
      end
      if ((state_reg == ST_LOAD) && (state_next == ST_BCAST)) begin
        mask_reg <= '0;
      end else if (capture_en) begin
        mask_reg <= mask_reg | nrn_outvalid;
      end
      // in_ready stays low for the layer_done cycle so the next vector
      // starts loading the cycle after it.
      in_ready_reg   <= (state_next == ST_LOAD) && (state_reg != ST_DRAIN);
      layer_done_reg <= out_fire && last_rd;
    end
  end

  // --------------------------------------------------------------------------
  // Activation buffer: write port in LOAD, registered read port in BCAST.
  // The read register is the broadcast register, giving a one-cycle-late,
  // gap-free nrn_valid burst.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_mem[wr_idx_reg[IAW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nrn_data_reg  <= '0;
      nrn_valid_reg <= 1'b0;
    end else begin
      nrn_valid_reg <= (state_reg == ST_BCAST);
      if (state_reg == ST_BCAST) begin
        nrn_data_reg <= buf_mem[bc_idx_reg[IAW-1:0]];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-neuron result capture; a repeat pulse simply overwrites.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_res
      always_ff @(posedge clk) begin
        if (capture_en && nrn_outvalid[gi]) begin
          res_reg[gi] <= nrn_out[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Optional WAIT watchdog
  // --------------------------------------------------------------------------
`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt_reg;
  logic          err_reg;

  // Counter is zero in the first WAIT cycle; the exit edge is the
  // TIMEOUT_CYCLES-th edge spent in WAIT.
  assign timeout_hit = (state_reg == ST_WAIT) && !mask_all &&
                       (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (state_reg == ST_WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + TW'(1);
      end else begin
        wait_cnt_reg <= '0;
      end
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign res_sel    = res_reg[rd_idx_reg[NAW-1:0]];
  assign out_valid  = (state_reg == ST_DRAIN);
  // A neuron that never reported (watchdog exit) drains as zero.
  assign out_data   = (out_valid && mask_reg[rd_idx_reg[NAW-1:0]]) ? res_sel : '0;

  assign in_ready   = in_ready_reg;
  assign nrn_data   = nrn_data_reg;
  assign nrn_valid  = nrn_valid_reg;
  assign layer_done = layer_done_reg;
  assign busy       = (state_reg != ST_LOAD) || (wr_idx_reg != '0);

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Testbench for layer_seq_ctrl (NUM_INPUTS=4, NUM_NEURONS=3, TIMEOUT_CYCLES=8).
// Stimulus is driven 1 time unit after the rising edge; monitors sample on
// the falling edge. Expected broadcast words and result words are queued by
// the stimulus side and popped by independent monitors.
module tb_layer_seq_ctrl;

  localparam int NI = 4;
  localparam int NN = 3;
  localparam int DW = 16;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     nrn_data;
  logic              nrn_valid;
  logic [NN*DW-1:0]  nrn_out = '0;
  logic [NN-1:0]     nrn_outvalid = '0;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              layer_done;
  logic              err;

  layer_seq_ctrl #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .nrn_data(nrn_data), .nrn_valid(nrn_valid),
    .nrn_out(nrn_out), .nrn_outvalid(nrn_outvalid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .layer_done(layer_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] bcast_q[$];
  logic [DW-1:0] out_q[$];
  bit            bcast_abort = 1'b0;

  // Stimulus tables, filled by the main sequence before each call.
  logic [DW-1:0] vec [NI];
  int            pd1 [NN];
  int            pd2 [NN];
  logic [DW-1:0] pv1 [NN];
  logic [DW-1:0] pv2 [NN];
  int            vec_id = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load vec[] with random in_valid gaps; expected broadcast words are queued
  // at the moment each sample is accepted.
  task automatic load_vec(input int gap_pct);
    int i = 0;
    int guard = 0;
    bit busy_seen = 1'b0;
    chk("busy_idle", busy, 0);
    while (i < NI && guard < 100) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = vec[i];
      end
      if (in_valid && in_ready) begin
        bcast_q.push_back(vec[i]);
        i++;
      end
      tick();
      guard++;
      if (i == 1 && !busy_seen) begin
        chk("busy_after_first_accept", busy, 1);
        busy_seen = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (guard >= 100) chk("load_timeout", i, NI);
    chk("in_ready_after_last", in_ready, 0);
    $display("vector %0d loaded: %04h %04h %04h %04h in %0d cycles",
             vec_id, vec[0], vec[1], vec[2], vec[3], guard);
    vec_id++;
  endtask

  task automatic wait_burst();
    int g = 0;
    while (!nrn_valid && g < 20) begin
      tick();
      g++;
    end
    if (g >= 20) chk("burst_start_timeout", nrn_valid, 1);
  endtask

  // Drive neuron pulses for nt cycles, t=0 being the first nrn_valid cycle.
  // Reference model: a neuron's result is the latest value pulsed while the
  // layer is broadcasting/waiting. Collection ends in the first cycle where all
  // neurons have reported and the burst has reached its last word (cycle NI-1);
  // later pulses are ignored. If collection never ends, missing results are 0.
  task automatic fire(input int nt);
    logic [DW-1:0] mres [NN];
    bit            mseen [NN];
    logic [NN-1:0] ov;
    bit            done = 1'b0;
    bit            just = 1'b0;
    bit            all;
    for (int i = 0; i < NN; i++) begin
      mres[i]  = '0;
      mseen[i] = 1'b0;
    end
    for (int t = 0; t < nt; t++) begin
      ov = '0;
      for (int i = 0; i < NN; i++) begin
        if (pd1[i] == t) begin
          ov[i] = 1'b1;
          nrn_out[i*DW +: DW] = pv1[i];
        end else if (pd2[i] == t) begin
          ov[i] = 1'b1;
          nrn_out[i*DW +: DW] = pv2[i];
        end
      end
      nrn_outvalid = ov;
      if (!done) begin
        all = 1'b1;
        for (int i = 0; i < NN; i++) begin
          if (ov[i]) begin
            mres[i]  = nrn_out[i*DW +: DW];
            mseen[i] = 1'b1;
          end
          all = all && mseen[i];
        end
        if (all && t >= NI - 1) begin
          done = 1'b1;
          just = 1'b1;
          for (int i = 0; i < NN; i++) out_q.push_back(mres[i]);
          chk("out_valid_low_at_complete", out_valid, 0);
        end
      end
      tick();
      if (just) begin
        chk("out_valid_after_complete", out_valid, 1);
        just = 1'b0;
      end
    end
    nrn_outvalid = '0;
    if (!done) begin
      for (int i = 0; i < NN; i++) out_q.push_back(mseen[i] ? mres[i] : '0);
    end
  endtask

  // Accept all results; optionally stall stall_len cycles on word stall_word.
  task automatic drain(input int stall_word, input int stall_len, input bit rnd, input bit exp_err);
    int hs = 0;
    int g = 0;
    int sl = stall_len;
    bit r;
    bit v;
    while (hs < NN && g < 200) begin
      if (out_valid && hs == stall_word && sl > 0) begin
        out_ready = 1'b0;
        sl--;
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      r = out_ready;
      v = out_valid;
      tick();
      g++;
      if (r && v) hs++;
    end
    out_ready = 1'b0;
    if (g >= 200) chk("drain_timeout", hs, NN);
    chk("layer_done_pulse", layer_done, 1);
    tick();
    chk("layer_done_single", layer_done, 0);
    chk("in_ready_after_done", in_ready, 1);
    chk("err_flag", err, exp_err);
  endtask

  task automatic rand_vec();
    for (int i = 0; i < NI; i++) vec[i] = 16'($urandom);
  endtask

  task automatic rand_pulses();
    for (int i = 0; i < NN; i++) begin
      pd1[i] = $urandom_range(0, 9);
      pv1[i] = 16'($urandom);
      pv2[i] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        pd2[i] = (pd1[i] + 1 + $urandom_range(0, 8)) % 10;
      end else begin
        pd2[i] = -1;
      end
    end
  endtask

  // Broadcast monitor
  int            mon_run = 0;
  logic [DW-1:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (nrn_valid) begin
        mon_run++;
        if (bcast_q.size() == 0) begin
          chk("nrn_valid_unexpected", nrn_valid, 0);
        end else begin
          mon_exp = bcast_q.pop_front();
          chk("nrn_data", nrn_data, mon_exp);
        end
      end else if (mon_run > 0) begin
        if (!bcast_abort) chk("burst_length", mon_run, NI);
        mon_run = 0;
      end
    end
  end

  // Result monitor
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] out_exp;
  int            out_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && prev_stall) chk("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) begin
          chk("out_valid_unexpected", out_valid, 0);
        end else begin
          out_exp = out_q.pop_front();
          chk("out_data", out_data, out_exp);
          $display("result %0d: got %04h expected %04h", out_cnt, out_data, out_exp);
          out_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    // 1. Reset
    rst = 1'b1;
    tick();
    tick();
    chk("reset_outputs", {in_ready, nrn_valid, nrn_data, out_valid, out_data, busy, layer_done, err}, 0);
    tick();
    chk("reset_outputs_3", {in_ready, nrn_valid, nrn_data, out_valid, out_data, busy, layer_done, err}, 0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_reset", in_ready, 1);

    // 2+3. Gapped load, skewed completion, backpressure on the second word
    vec[0] = 16'h0010; vec[1] = 16'h0020; vec[2] = 16'h0030; vec[3] = 16'h0040;
    load_vec(50);
    wait_burst();
    pd1[0] = NI - 1 + 2; pd1[1] = NI - 1 + 5; pd1[2] = NI - 1 + 5;
    pv1[0] = 16'h0100;   pv1[1] = 16'h0200;   pv1[2] = 16'h0300;
    for (int i = 0; i < NN; i++) pd2[i] = -1;
    fire(10);
    drain(1, 3, 1'b0, 1'b0);

    // 6. Back-to-back vectors, then randomized vectors
    for (int k = 0; k < 8; k++) begin
      rand_vec();
      load_vec((k < 2) ? 0 : 40);
      wait_burst();
      rand_pulses();
      fire(12);
      drain(-1, 0, (k >= 2), 1'b0);
    end

`ifdef LAYER_SEQ_TIMEOUT_EN
    // 4. Watchdog: neuron 2 never reports
    rand_vec();
    load_vec(0);
    wait_burst();
    pd1[0] = 1; pd1[1] = 4; pd1[2] = -1;
    pv1[0] = 16'($urandom); pv1[1] = 16'($urandom); pv1[2] = 16'h5555;
    for (int i = 0; i < NN; i++) pd2[i] = -1;
    fire(NI - 1 + TO - 1);
    chk("err_before_timeout", err, 0);
    tick();
    chk("err_at_timeout", err, 1);
    drain(-1, 0, 1'b1, 1'b1);
`endif

    // 5. Reset on the second broadcast cycle
    rand_vec();
    load_vec(0);
    wait_burst();
    tick();
    bcast_abort = 1'b1;
    rst = 1'b1;
    tick();
    chk("nrn_valid_after_reset", nrn_valid, 0);
    chk("busy_after_reset", busy, 0);
    rst = 1'b0;
    tick();
    tick();
    bcast_q.delete();
    bcast_abort = 1'b0;
    chk("err_cleared_by_reset", err, 0);
    chk("in_ready_after_mid_reset", in_ready, 1);
    rand_vec();
    load_vec(20);
    wait_burst();
    rand_pulses();
    fire(12);
    drain(-1, 0, 1'b1, 1'b0);

    tick();
    tick();
    chk("bcast_queue_empty", bcast_q.size(), 0);
    chk("out_queue_empty", out_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
